// File: rtl/core_run_ctrl_if.sv
// Program-load port of the run controller: the host streams instruction words,
// and the controller accepts them one per cycle while it is loading.
interface core_run_ctrl_if;
  // A word transfers on every rising edge where prog_valid_i && prog_ready_o.
  // The host holds data/last stable while valid is high and ready is low.
  // prog_last_i only has meaning on a transferring beat.
  logic        prog_valid_i;
  logic        prog_ready_o;
  logic [31:0] prog_data_i;
  logic        prog_last_i;

  modport master (
    output prog_valid_i,
    output prog_data_i,
    output prog_last_i,
    input  prog_ready_o
  );

  modport slave (
    input  prog_valid_i,
    input  prog_data_i,
    input  prog_last_i,
    output prog_ready_o
  );
endinterface

// File: rtl/core_run_ctrl.sv
// Load-run-report controller for the single-cycle core: streams a program into
// imem, releases the core for a bounded run, then records why and when it halted.
module core_run_ctrl #(
  parameter int IMEM_DEPTH = 64,
  parameter int CYC_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  core_run_ctrl_if.slave   prog,
  input  logic             start_i,
  input  logic [CYC_W-1:0] max_cycles_i,
  input  logic [31:0]      core_pc_i,
  input  logic [31:0]      core_instr_i,
  output logic             core_rst_o,
  output logic             imem_we_o,
  output logic [31:0]      imem_waddr_o,
  output logic [31:0]      imem_wdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       halt_cause_o,
  output logic [CYC_W-1:0] cycles_o,
  output logic [2:0]       dbg_state_o
);

  localparam int               AW       = $clog2(IMEM_DEPTH);
  localparam logic [AW-1:0]    LAST_IDX = AW'(IMEM_DEPTH - 1);
  localparam logic [CYC_W-1:0] CYC_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_RESET_CORE = 3'd2,
    S_RUN        = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    word_cnt;
  logic             rc_cnt;
  logic [CYC_W-1:0] k, k_next, budget;
  logic [31:0]      prev_pc;
  logic             hist_valid;
  logic             load_ready, beat, beat_last;
  logic             hit_ecall, hit_loop, hit_tmo, halt;
  logic [1:0]       cause_nxt;
  logic             we_q;
  logic [31:0]      waddr_q, wdata_q;

  assign load_ready = (state == S_LOAD);
  assign beat       = load_ready && prog.prog_valid_i;
  assign beat_last  = beat && (prog.prog_last_i || (word_cnt == LAST_IDX));

  // Halt checks in priority order; k_next saturates so an unlimited run never wraps.
  always_comb begin
    k_next    = (k == CYC_MAX) ? k : k + CYC_W'(1);
    hit_ecall = (core_instr_i == 32'h0000_0073);
    hit_loop  = hist_valid && (core_pc_i == prev_pc);
    hit_tmo   = (budget != '0) && (k_next == budget);
    cause_nxt = 2'd0;
    if (hit_ecall)     cause_nxt = 2'd1;
    else if (hit_loop) cause_nxt = 2'd2;
    else if (hit_tmo)  cause_nxt = 2'd3;
    halt = (state == S_RUN) && (cause_nxt != 2'd0);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (start_i) state_nxt = S_LOAD;
      S_LOAD:       if (beat_last) state_nxt = S_RESET_CORE;
      S_RESET_CORE: if (rc_cnt) state_nxt = S_RUN;
      S_RUN:        if (halt) state_nxt = S_DONE;
      S_DONE:       if (start_i) state_nxt = S_LOAD;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    core_rst_o        = (state != S_RUN);
    busy_o            = (state == S_LOAD) || (state == S_RESET_CORE) || (state == S_RUN);
    done_o            = (state == S_DONE);
    prog.prog_ready_o = load_ready;
    dbg_state_o       = state;
  end

  // rc_cnt toggles twice across RESET_CORE, so it is back at 0 on every entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt     <= '0;
      rc_cnt       <= 1'b0;
      k            <= '0;
      budget       <= '0;
      prev_pc      <= '0;
      hist_valid   <= 1'b0;
      cycles_o     <= '0;
      halt_cause_o <= 2'd0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      we_q <= beat;
      if (beat) begin
        waddr_q  <= {{(30-AW){1'b0}}, word_cnt, 2'b00};
        wdata_q  <= prog.prog_data_i;
        word_cnt <= word_cnt + AW'(1);
      end
      case (state)
        S_IDLE, S_DONE: begin
          if (start_i) word_cnt <= '0;
        end
        S_RESET_CORE: begin
          rc_cnt       <= ~rc_cnt;
          k            <= '0;
          hist_valid   <= 1'b0;
          cycles_o     <= '0;
          halt_cause_o <= 2'd0;
          budget       <= max_cycles_i;
        end
        S_RUN: begin
          k          <= k_next;
          prev_pc    <= core_pc_i;
          hist_valid <= 1'b1;
          if (halt) begin
            cycles_o     <= k_next;
            halt_cause_o <= cause_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_we_o    = we_q;
  assign imem_waddr_o = waddr_q;
  assign imem_wdata_o = wdata_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: a tiny core model fetches from the words the
// controller writes, and each run's writes, release timing and halt report are checked.
`timescale 1ns/1ps
module tb_core_run_ctrl;
  localparam int DEPTH = 64;
  localparam int CW    = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic [CW-1:0]  max_cycles = '0;
  logic [31:0]    core_pc, core_instr;
  logic           core_rst_o, imem_we_o, busy_o, done_o;
  logic [31:0]    imem_waddr_o, imem_wdata_o;
  logic [1:0]     halt_cause_o;
  logic [CW-1:0]  cycles_o;
  logic [2:0]     dbg_state_o;

  core_run_ctrl_if prog_if ();

  core_run_ctrl #(.IMEM_DEPTH(DEPTH), .CYC_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .prog         (prog_if),
    .start_i      (start),
    .max_cycles_i (max_cycles),
    .core_pc_i    (core_pc),
    .core_instr_i (core_instr),
    .core_rst_o   (core_rst_o),
    .imem_we_o    (imem_we_o),
    .imem_waddr_o (imem_waddr_o),
    .imem_wdata_o (imem_wdata_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .halt_cause_o (halt_cause_o),
    .cycles_o     (cycles_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- core model: pc+4 each cycle, jal x0,0 spins ----------------
  logic [31:0] tb_mem [DEPTH];
  logic [31:0] pc;

  always @(posedge clk or negedge rst) begin
    if (!rst)                       pc <= '0;
    else if (core_rst_o)            pc <= '0;
    else if (core_instr == 32'h6F)  pc <= pc;
    else                            pc <= pc + 32'd4;
  end

  assign core_pc    = pc;
  assign core_instr = (pc < 32'(DEPTH * 4)) ? tb_mem[pc[7:2]] : 32'h0;

  // ---------------- scoreboard ----------------
  logic [63:0] got_q[$];
  logic [63:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [1:0] prev_cause = 2'd0;

  always @(negedge clk) begin
    if (imem_we_o) begin
      got_q.push_back({imem_waddr_o, imem_wdata_o});
      if (imem_waddr_o < 32'(DEPTH * 4)) tb_mem[imem_waddr_o[7:2]] = imem_wdata_o;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 32'h0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic compare_writes();
    chk("write_count", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk($sformatf("write[%0d]_addr_data", i), got_q[i], exp_q[i]);
  endtask

  // ---------------- driver tasks ----------------
  typedef struct packed {
    logic [2:0]       n;
    logic [3:0][31:0] w;
    logic [CW-1:0]    budget;
    logic [1:0]       cause;
    logic [CW-1:0]    cyc;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [31:0] w0, w1, w2, w3,
                              input int budget, input int cause, input int cyc);
    vec_t v;
    v.n = 3'(n);
    v.w = {w3, w2, w1, w0};
    v.budget = CW'(budget);
    v.cause = 2'(cause);
    v.cyc = CW'(cyc);
    return v;
  endfunction

  task automatic start_load();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("load_busy", busy_o, 1'b1);
    chk("load_ready", prog_if.prog_ready_o, 1'b1);
    chk("load_done_clear", done_o, 1'b0);
    chk("load_cause_held", halt_cause_o, prev_cause);
  endtask

  // Ends in the first RUN cycle.
  task automatic load_prog(input vec_t v);
    clear_mem();
    for (int i = 0; i < int'(v.n); i++) exp_q.push_back({32'(4 * i), v.w[i]});
    max_cycles = v.budget;
    start_load();
    for (int i = 0; i < int'(v.n); i++) begin
      prog_if.prog_valid_i = 1'b1;
      prog_if.prog_data_i  = v.w[i];
      prog_if.prog_last_i  = (i == int'(v.n) - 1);
      @(posedge clk); #1;
    end
    prog_if.prog_valid_i = 1'b0;
    prog_if.prog_last_i  = 1'b0;
    chk("ready_after_last", prog_if.prog_ready_o, 1'b0);
    chk("rc1_core_rst", core_rst_o, 1'b1);
    chk("rc1_busy", busy_o, 1'b1);
    @(posedge clk); #1;
    chk("rc2_core_rst", core_rst_o, 1'b1);
    @(posedge clk); #1;
    chk("run_release", core_rst_o, 1'b0);
    compare_writes();
  endtask

  task automatic wait_done(input logic [1:0] cause, input logic [CW-1:0] cyc, input bit chk_runs);
    int runs = 0;
    for (int c = 0; c < 500; c++) begin
      if (done_o) break;
      if (!core_rst_o) runs++;
      @(posedge clk); #1;
    end
    chk("done_reached", done_o, 1'b1);
    chk("done_core_rst", core_rst_o, 1'b1);
    chk("done_busy", busy_o, 1'b0);
    chk("halt_cause", halt_cause_o, cause);
    chk("cycles", cycles_o, cyc);
    if (chk_runs) chk("run_cycles_seen", 64'(runs), 64'(cyc));
    @(posedge clk); #1;
    chk("done_held", done_o, 1'b1);
    chk("cycles_held", cycles_o, cyc);
    prev_cause = cause;
  endtask

  task automatic run_vec(input vec_t v);
    load_prog(v);
    wait_done(v.cause, v.cyc, 1'b1);
  endtask

  // ---------------- test ----------------
  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = mk(3, 32'h00500093, 32'h00108113, 32'h00000073, 32'h0, 0, 1, 3);
    tbl[1] = mk(1, 32'h0000006F, 32'h0, 32'h0, 32'h0, 0, 2, 2);
    tbl[2] = mk(4, 32'h13, 32'h13, 32'h13, 32'h13, 10, 3, 10);
    tbl[3] = mk(1, 32'h00000073, 32'h0, 32'h0, 32'h0, 1, 1, 1);  // ecall beats timeout
    tbl[4] = mk(1, 32'h0000006F, 32'h0, 32'h0, 32'h0, 2, 2, 2);  // self-loop beats timeout
    tbl[5] = mk(3, 32'h13, 32'h13, 32'h0000006F, 32'h0, 0, 2, 4);
    tbl[6] = mk(2, 32'h13, 32'h13, 32'h0, 32'h0, 1, 3, 1);

    prog_if.prog_valid_i = 1'b0;
    prog_if.prog_data_i  = '0;
    prog_if.prog_last_i  = 1'b0;
    clear_mem();

    repeat (3) @(posedge clk);
    #1;
    chk("rst_core_rst", core_rst_o, 1'b1);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_ready", prog_if.prog_ready_o, 1'b0);
    chk("rst_we", imem_we_o, 1'b0);
    chk("rst_cause", halt_cause_o, 2'd0);
    chk("rst_cycles", cycles_o, '0);
    chk("rst_state", dbg_state_o, 3'd0);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_core_rst", core_rst_o, 1'b1);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Truncation: DEPTH+5 words, no last, two stalled cycles mid-stream.
    clear_mem();
    for (int i = 0; i < DEPTH; i++) exp_q.push_back({32'(4 * i), 32'h1000 + 32'(i)});
    max_cycles = CW'(5);
    start_load();
    begin
      int sent = 0;
      for (int c = 0; sent < DEPTH + 5; c++) begin
        if (c == 10 || c == 11) begin
          prog_if.prog_valid_i = 1'b0;
        end else begin
          prog_if.prog_valid_i = 1'b1;
          prog_if.prog_data_i  = 32'h1000 + 32'(sent);
          sent++;
        end
        @(posedge clk); #1;
        if (c == 10) chk("stall_no_write", imem_we_o, 1'b0);
        if (prog_if.prog_valid_i && sent == DEPTH)
          chk("ready_low_after_autolast", prog_if.prog_ready_o, 1'b0);
      end
    end
    prog_if.prog_valid_i = 1'b0;
    compare_writes();
    chk("trunc_last_addr", got_q[$][63:32], 32'(4 * (DEPTH - 1)));
    wait_done(2'd3, CW'(5), 1'b0);

    // start_i during RUN is ignored, then async reset mid-RUN.
    load_prog(mk(1, 32'h13, 32'h0, 32'h0, 32'h0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("run_start_ignored_busy", busy_o, 1'b1);
    chk("run_start_ignored_core_rst", core_rst_o, 1'b0);
    chk("run_start_ignored_done", done_o, 1'b0);
    #1 rst = 1'b0;
    #1;
    chk("run_rst_core_rst", core_rst_o, 1'b1);
    chk("run_rst_busy", busy_o, 1'b0);
    chk("run_rst_done", done_o, 1'b0);
    chk("run_rst_state", dbg_state_o, 3'd0);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;
    chk("run_rst_stays_idle", busy_o, 1'b0);
    prev_cause = 2'd0;

    // Async reset mid-LOAD drops the in-flight write of the second beat.
    clear_mem();
    exp_q.push_back({32'h0, 32'hAAAA_0001});
    start_load();
    prog_if.prog_valid_i = 1'b1;
    prog_if.prog_data_i  = 32'hAAAA_0001;
    @(posedge clk); #1;
    prog_if.prog_data_i  = 32'hAAAA_0002;
    @(posedge clk); #1;
    rst = 1'b0;
    prog_if.prog_valid_i = 1'b0;
    #1;
    chk("load_rst_we", imem_we_o, 1'b0);
    chk("load_rst_ready", prog_if.prog_ready_o, 1'b0);
    chk("load_rst_busy", busy_o, 1'b0);
    chk("load_rst_core_rst", core_rst_o, 1'b1);
    @(posedge clk); #2 rst = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    compare_writes();
    chk("load_rst_idle_state", dbg_state_o, 3'd0);

    // Recovery run after the resets.
    run_vec(tbl[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
